// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types and constants for the memory-port arbiter.
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} arb_state_t;
  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LSU = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction
endpackage

// File: rtl/riscv_rr_arbiter.sv
// riscv_rr_arbiter: three-way round-robin pick starting after the last owner.
module riscv_rr_arbiter
  import riscv_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] grant
);
  always_comb
    grant = (last == REQ_FETCH) ?
              (req[REQ_LSU] ? 3'b010 : req[REQ_DBG] ? 3'b100 : req[REQ_FETCH] ? 3'b001 : 3'b000) :
            (last == REQ_LSU) ?
              (req[REQ_DBG] ? 3'b100 : req[REQ_FETCH] ? 3'b001 : req[REQ_LSU] ? 3'b010 : 3'b000) :
              (req[REQ_FETCH] ? 3'b001 : req[REQ_LSU] ? 3'b010 : req[REQ_DBG] ? 3'b100 : 3'b000);
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: single-outstanding arbiter of fetch/LSU/debug onto one memory port,
// with a WAIT timeout that self-completes and later swallows the stale response.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       req_i,
  input  logic [2:0][31:0] addr_i,
  input  logic [2:0]       we_i,
  input  logic [2:0][1:0]  size_i,
  input  logic [2:0][31:0] wdata_i,
  output logic [2:0]       gnt_o,
  output logic [2:0]       rvalid_o,
  output logic [2:0]       err_o,
  output logic [31:0]      rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [1:0]       mem_size_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic             mem_err_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o,
  output logic [1:0]       owner_o
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  arb_state_t  state_q, state_d;
  logic [1:0]  owner_q, owner_d, last_q, last_d, size_q, size_d, gidx;
  logic [15:0] cnt_q, cnt_d;
  logic        drop_q, drop_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  grant, oh;
  logic        in_req, in_wait, resp_ok, resp_to;
  riscv_rr_arbiter u_arb (.req(req_i), .last(last_q), .grant(grant));
  assign gidx    = grant[REQ_LSU] ? REQ_LSU : grant[REQ_DBG] ? REQ_DBG : REQ_FETCH;
  assign in_req  = state_q == REQ;
  assign in_wait = state_q == WAIT;
  assign resp_ok = in_wait && mem_rvalid_i;
  // A real response on the final WAIT cycle beats the timeout
  assign resp_to = in_wait && !mem_rvalid_i && cnt_q == TO_LAST;
  assign oh      = onehot3(owner_q);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    if (state_q == IDLE) begin
      if (drop_q && mem_rvalid_i) drop_d = 1'b0;
      if (!drop_q && |req_i) begin
        state_d = REQ;
        owner_d = gidx;
        addr_d  = addr_i[gidx];
        we_d    = we_i[gidx];
        size_d  = size_i[gidx];
        wdata_d = wdata_i[gidx];
      end
    end
    if (in_req && mem_gnt_i) begin
      state_d = WAIT;
      cnt_d   = '0;
    end
    if (in_wait) begin
      cnt_d = cnt_q + 16'd1;
      if (resp_ok || resp_to) begin
        state_d = IDLE;
        last_d  = owner_q;
        drop_d  = resp_to;
      end
    end
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= REQ_FETCH;
      last_q  <= REQ_DBG;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  // Outputs are forced low while reset is held, even before the first edge
  assign gnt_o       = (reset_n && in_req && mem_gnt_i) ? oh : '0;
  assign rvalid_o    = (reset_n && (resp_ok || resp_to)) ? oh : '0;
  assign err_o       = (reset_n && (resp_to || (resp_ok && mem_err_i))) ? oh : '0;
  assign rdata_o     = (reset_n && resp_ok) ? mem_rdata_i : '0;
  assign mem_req_o   = reset_n && in_req;
  assign mem_we_o    = reset_n && we_q;
  assign mem_size_o  = reset_n ? size_q : '0;
  assign mem_addr_o  = reset_n ? addr_q : '0;
  assign mem_wdata_o = reset_n ? wdata_q : '0;
  assign busy_o      = reset_n && state_q != IDLE;
  assign owner_o     = reset_n ? owner_q : '0;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks of arbitration order, handshake, timeout/drop and reset.
module tb_riscv_mem_arbiter;
  logic             clock = 1'b0;
  logic             reset_n;
  logic [2:0]       req_i, we_i;
  logic [2:0][31:0] addr_i, wdata_i;
  logic [2:0][1:0]  size_i;
  logic [2:0]       gnt_o, rvalid_o, err_o;
  logic [31:0]      rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic             mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, busy_o;
  logic [1:0]       mem_size_o, owner_o;
  int               passed = 0;
  int               total = 0;
  int               gcount;
  logic [2:0]       seq [4];

  riscv_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .size_i(size_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset_n = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; size_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    #1;
    chk("during_reset_busy", 32'(busy_o), 0);
    chk("during_reset_rvalid", 32'(rvalid_o), 0);
    nxt();
    nxt();
    reset_n = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_owner", 32'(owner_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", 32'(err_o), 0);
    // Round robin under all-request with a zero-wait memory
    req_i = 3'b111; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_idle_gnt", 32'(gnt_o), 0);
      chk("rr_idle_busy", 32'(busy_o), 0);
      nxt();
      #1;
      chk("rr_gnt", 32'(gnt_o), 32'(seq[k]));
      chk("rr_mem_req", 32'(mem_req_o), 1);
      nxt();
      #1;
      chk("rr_rvalid", 32'(rvalid_o), 32'(seq[k]));
      chk("rr_rdata", rdata_o, 32'h1111_1111);
      nxt();
    end
    req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    // Fetch read with 2 REQ and 3 WAIT cycles
    req_i = 3'b001; addr_i[0] = 32'h0000_0100; size_i[0] = 2'b10; gcount = 0;
    #1;
    chk("rd_idle_busy", 32'(busy_o), 0);
    nxt();
    #1;
    chk("rd_req1_addr", mem_addr_o, 32'h0000_0100);
    chk("rd_req1_we", 32'(mem_we_o), 0);
    if (gnt_o == 3'b001) gcount++;
    nxt();
    mem_gnt_i = 1'b1;
    #1;
    chk("rd_req2_gnt", 32'(gnt_o), 32'b001);
    if (gnt_o == 3'b001) gcount++;
    for (int w = 0; w < 2; w++) begin
      nxt();
      mem_gnt_i = 1'b0; req_i = '0;
      #1;
      chk("rd_wait_rvalid", 32'(rvalid_o), 0);
      if (gnt_o == 3'b001) gcount++;
    end
    nxt();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid", 32'(rvalid_o), 32'b001);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err_o), 0);
    if (gnt_o == 3'b001) gcount++;
    nxt();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #1;
    chk("rd_busy_fall", 32'(busy_o), 0);
    chk("rd_rdata_idle", rdata_o, 0);
    chk("rd_gnt_once", 32'(gcount), 1);
    // LSU byte store: payload held stable over 3 REQ cycles
    req_i = 3'b010; we_i = 3'b010; addr_i[1] = 32'h0000_2003; wdata_i[1] = 32'h0000_00A5; size_i[1] = 2'b00;
    for (int r = 0; r < 3; r++) begin
      nxt();
      mem_gnt_i = (r == 2);
      #1;
      chk("st_we", 32'(mem_we_o), 1);
      chk("st_size", 32'(mem_size_o), 0);
      chk("st_addr", mem_addr_o, 32'h0000_2003);
      chk("st_wdata", mem_wdata_o, 32'h0000_00A5);
      chk("st_gnt", 32'(gnt_o), (r == 2) ? 32'b010 : 32'b000);
    end
    nxt();
    mem_gnt_i = 1'b0; req_i = '0; we_i = '0;
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    chk("st_rvalid", 32'(rvalid_o), 32'b010);
    chk("st_err", 32'(err_o), 32'b010);
    chk("st_rdata", rdata_o, 32'h1234_5678);
    nxt();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    #1;
    chk("st_busy_fall", 32'(busy_o), 0);
    // Debug read that times out, then a late response is swallowed
    req_i = 3'b100; addr_i[2] = 32'h0000_3000;
    nxt();
    mem_gnt_i = 1'b1;
    #1;
    chk("to_gnt", 32'(gnt_o), 32'b100);
    for (int w = 0; w < 3; w++) begin
      nxt();
      mem_gnt_i = 1'b0; req_i = '0; mem_rdata_i = 32'hCAFE_F00D;
      #1;
      chk("to_wait_rvalid", 32'(rvalid_o), 0);
    end
    nxt();
    #1;
    chk("to_rvalid", 32'(rvalid_o), 32'b100);
    chk("to_err", 32'(err_o), 32'b100);
    chk("to_rdata", rdata_o, 0);
    nxt();
    req_i = 3'b001;
    #1;
    chk("drop_idle1_busy", 32'(busy_o), 0);
    nxt();
    #1;
    chk("drop_idle2_busy", 32'(busy_o), 0);
    nxt();
    mem_rvalid_i = 1'b1;
    #1;
    chk("drop_swallow_rvalid", 32'(rvalid_o), 0);
    chk("drop_swallow_busy", 32'(busy_o), 0);
    nxt();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #1;
    chk("drop_arb_busy", 32'(busy_o), 0);
    nxt();
    mem_gnt_i = 1'b1;
    #1;
    chk("drop_after_busy", 32'(busy_o), 1);
    chk("drop_after_gnt", 32'(gnt_o), 32'b001);
    nxt();
    mem_gnt_i = 1'b0; req_i = '0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    #1;
    chk("drop_after_rvalid", 32'(rvalid_o), 32'b001);
    chk("drop_after_rdata", rdata_o, 32'h0BAD_F00D);
    nxt();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    // Response on the final WAIT cycle wins over the timeout
    req_i = 3'b010;
    nxt();
    mem_gnt_i = 1'b1;
    #1;
    chk("race_gnt", 32'(gnt_o), 32'b010);
    for (int w = 0; w < 3; w++) begin
      nxt();
      mem_gnt_i = 1'b0; req_i = '0;
      #1;
      chk("race_wait_rvalid", 32'(rvalid_o), 0);
    end
    nxt();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA_55AA;
    #1;
    chk("race_rvalid", 32'(rvalid_o), 32'b010);
    chk("race_err", 32'(err_o), 0);
    chk("race_rdata", rdata_o, 32'h55AA_55AA);
    nxt();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; req_i = 3'b001;
    #1;
    chk("race_idle_busy", 32'(busy_o), 0);
    nxt();
    mem_gnt_i = 1'b1;
    #1;
    chk("race_no_drop_busy", 32'(busy_o), 1);
    chk("race_no_drop_gnt", 32'(gnt_o), 32'b001);
    nxt();
    mem_gnt_i = 1'b0; req_i = '0; mem_rvalid_i = 1'b1;
    #1;
    chk("race_next_rvalid", 32'(rvalid_o), 32'b001);
    nxt();
    mem_rvalid_i = 1'b0;
    // Reset during a debug WAIT
    req_i = 3'b100; addr_i[2] = 32'h0000_4000;
    nxt();
    mem_gnt_i = 1'b1;
    #1;
    chk("rw_gnt", 32'(gnt_o), 32'b100);
    chk("rw_owner", 32'(owner_o), 2);
    nxt();
    mem_gnt_i = 1'b0; req_i = '0;
    #1;
    chk("rw_wait_busy", 32'(busy_o), 1);
    reset_n = 1'b0;
    #1;
    chk("rw_during_busy", 32'(busy_o), 0);
    nxt();
    reset_n = 1'b1;
    #1;
    chk("rw_after_busy", 32'(busy_o), 0);
    chk("rw_after_owner", 32'(owner_o), 0);
    chk("rw_after_mem_req", 32'(mem_req_o), 0);
    chk("rw_after_addr", mem_addr_o, 0);
    chk("rw_after_rvalid", 32'(rvalid_o), 0);
    req_i = 3'b101; mem_gnt_i = 1'b1; addr_i[0] = 32'h0000_0500;
    nxt();
    #1;
    chk("rw_first_gnt", 32'(gnt_o), 32'b001);
    chk("rw_first_addr", mem_addr_o, 32'h0000_0500);
    nxt();
    mem_gnt_i = 1'b0; req_i = 3'b100; mem_rvalid_i = 1'b1;
    #1;
    chk("rw_first_rvalid", 32'(rvalid_o), 32'b001);
    nxt();
    mem_rvalid_i = 1'b0;
    nxt();
    #1;
    chk("rw_second_owner", 32'(owner_o), 2);
    chk("rw_second_busy", 32'(busy_o), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
